// File: rtl/sd_card_pkg.sv
// Shared types, constants and the serial CRC7 step for the SD card CMD-line responder.
package sd_card_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StCheck,
        StWaitNcr,
        StSend
    } state_e;

    localparam int unsigned CmdLen   = 48;
    localparam int unsigned CrcWidth = 7;
    localparam logic [CrcWidth-1:0] CrcPoly = 7'h09;

    // One MSB-first step of x^7 + x^3 + 1.
    function automatic logic [CrcWidth-1:0] crc7_next(input logic [CrcWidth-1:0] crc,
                                                      input logic din);
        logic fb;
        fb = crc[CrcWidth-1] ^ din;
        return {crc[CrcWidth-2:0], 1'b0} ^ (fb ? CrcPoly : '0);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clear together with enable starts a fresh CRC that includes bit_i.
module sd_crc7
    import sd_card_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                bit_i,
    output logic [CrcWidth-1:0] crc_o
);

    logic [CrcWidth-1:0] crc_q, crc_d, crc_base;

    always_comb begin
        crc_base = clr_i ? '0 : crc_q;
        crc_d    = crc_base;
        if (en_i) begin
            crc_d = crc7_next(crc_base, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line endpoint: receives 48-bit host commands and answers with R1 responses.
// Optional SD_CARD_RSP_CRC_INJECT_EN adds rsp_crc_inject_i to invert the response CRC.
module sd_card_cmd_responder
    import sd_card_pkg::*;
#(
    parameter int unsigned NcrCycles = 2,
    parameter logic [63:0] NoRspMask = 64'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sd_clk_en_i,
    input  logic        sd_cmd_i,
    output logic        sd_cmd_o,
    output logic        sd_cmd_en_o,
    input  logic [31:0] card_status_i,
`ifdef SD_CARD_RSP_CRC_INJECT_EN
    input  logic        rsp_crc_inject_i,
`endif
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        cmd_err_o,
    output logic        busy_o
);

    localparam logic [5:0] NcrLast = 6'(NcrCycles - 1);

    state_e        state_q, state_d;
    logic [46:0]   rx_q, rx_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [5:0]    ncr_cnt_q, ncr_cnt_d;
    logic [38:0]   tx_q, tx_d;
    logic          inject_q, inject_d;
    logic          cmd_q, cmd_d;
    logic          cmd_en_q, cmd_en_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [5:0]    index_q, index_d;
    logic [31:0]   arg_q, arg_d;

    logic                rx_crc_clr, rx_crc_en;
    logic                tx_crc_clr, tx_crc_en, tx_crc_bit;
    logic [CrcWidth-1:0] rx_crc, tx_crc;
    logic [2:0]          crc_sel;
    logic                rx_pass;
    logic                inject_in;

`ifdef SD_CARD_RSP_CRC_INJECT_EN
    assign inject_in = rsp_crc_inject_i;
`else
    assign inject_in = 1'b0;
`endif

    sd_crc7 u_rx_crc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (rx_crc_clr),
        .en_i  (rx_crc_en),
        .bit_i (sd_cmd_i),
        .crc_o (rx_crc)
    );

    sd_crc7 u_tx_crc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tx_crc_clr),
        .en_i  (tx_crc_en),
        .bit_i (tx_crc_bit),
        .crc_o (tx_crc)
    );

    // rx_q holds frame bits 46..0 once the end bit is in; the start bit is implicitly 0.
    assign rx_pass = rx_q[46] && (rx_crc == rx_q[7:1]) && rx_q[0];
    assign crc_sel = 3'(6'd46 - bit_cnt_q);

    always_comb begin
        state_d    = state_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        ncr_cnt_d  = ncr_cnt_q;
        tx_d       = tx_q;
        inject_d   = inject_q;
        cmd_d      = cmd_q;
        cmd_en_d   = cmd_en_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        index_d    = index_q;
        arg_d      = arg_q;
        rx_crc_clr = 1'b0;
        rx_crc_en  = 1'b0;
        tx_crc_clr = 1'b0;
        tx_crc_en  = 1'b0;
        tx_crc_bit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sd_clk_en_i && !sd_cmd_i) begin
                    rx_crc_clr = 1'b1;
                    rx_crc_en  = 1'b1;
                    bit_cnt_d  = 6'd1;
                    state_d    = StRecv;
                end
            end
            StRecv: begin
                if (sd_clk_en_i) begin
                    rx_d      = {rx_q[45:0], sd_cmd_i};
                    rx_crc_en = (bit_cnt_q < 6'd40);
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'(CmdLen - 1)) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (rx_pass) begin
                    valid_d   = 1'b1;
                    index_d   = rx_q[45:40];
                    arg_d     = rx_q[39:8];
                    ncr_cnt_d = '0;
                    state_d   = NoRspMask[rx_q[45:40]] ? StIdle : StWaitNcr;
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitNcr: begin
                if (sd_clk_en_i) begin
                    if (ncr_cnt_q == NcrLast) begin
                        // Start bit goes out now and also seeds the response CRC.
                        tx_d       = {1'b0, index_q, card_status_i};
                        inject_d   = inject_in;
                        cmd_en_d   = 1'b1;
                        cmd_d      = 1'b0;
                        tx_crc_clr = 1'b1;
                        tx_crc_en  = 1'b1;
                        bit_cnt_d  = 6'd1;
                        state_d    = StSend;
                    end else begin
                        ncr_cnt_d = ncr_cnt_q + 6'd1;
                    end
                end
            end
            StSend: begin
                if (sd_clk_en_i) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q < 6'd40) begin
                        cmd_d      = tx_q[38];
                        tx_d       = {tx_q[37:0], 1'b0};
                        tx_crc_en  = 1'b1;
                        tx_crc_bit = tx_q[38];
                    end else if (bit_cnt_q < 6'd47) begin
                        cmd_d = tx_crc[crc_sel] ^ inject_q;
                    end else if (bit_cnt_q == 6'd47) begin
                        cmd_d = 1'b1;
                    end else begin
                        cmd_en_d = 1'b0;
                        cmd_d    = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            ncr_cnt_q <= '0;
            tx_q      <= '0;
            inject_q  <= 1'b0;
            cmd_q     <= 1'b1;
            cmd_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            index_q   <= '0;
            arg_q     <= '0;
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            ncr_cnt_q <= ncr_cnt_d;
            tx_q      <= tx_d;
            inject_q  <= inject_d;
            cmd_q     <= cmd_d;
            cmd_en_q  <= cmd_en_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            index_q   <= index_d;
            arg_q     <= arg_d;
        end
    end

    assign sd_cmd_o    = cmd_q;
    assign sd_cmd_en_o = cmd_en_q;
    assign cmd_valid_o = valid_q;
    assign cmd_err_o   = err_q;
    assign cmd_index_o = index_q;
    assign cmd_arg_o   = arg_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Randomised bench for sd_card_cmd_responder against a frame-level reference model.
module tb_sd_card_cmd_responder;

    localparam int unsigned NCR    = 2;
    localparam logic [63:0] NO_RSP = 64'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sd_cmd_in = 1'b1;
    logic        sd_cmd_out, sd_cmd_en;
    logic [31:0] card_status = '0;
    logic        cmd_valid, cmd_err, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  div = '0;
    logic        sd_clk_en;
`ifdef SD_CARD_RSP_CRC_INJECT_EN
    logic        rsp_crc_inject = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int valid_pulses = 0;
    int err_pulses = 0;
    logic [5:0]  last_idx = '0;
    logic [31:0] last_arg = '0;
    logic [47:0] rsp_got;

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign sd_clk_en = (div == 2'd3);

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) valid_pulses++;
        if (cmd_err === 1'b1) err_pulses++;
    end

    sd_card_cmd_responder #(
        .NcrCycles (NCR),
        .NoRspMask (NO_RSP)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .sd_clk_en_i      (sd_clk_en),
        .sd_cmd_i         (sd_cmd_in),
        .sd_cmd_o         (sd_cmd_out),
        .sd_cmd_en_o      (sd_cmd_en),
        .card_status_i    (card_status),
`ifdef SD_CARD_RSP_CRC_INJECT_EN
        .rsp_crc_inject_i (rsp_crc_inject),
`endif
        .cmd_valid_o      (cmd_valid),
        .cmd_index_o      (cmd_index),
        .cmd_arg_o        (cmd_arg),
        .cmd_err_o        (cmd_err),
        .busy_o           (busy)
    );

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        end
        return v[6:0];
    endfunction

    task automatic wait_pulse();
        @(negedge clk);
        while (!sd_clk_en) @(negedge clk);
    endtask

    task automatic sample_pulse();
        wait_pulse();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] frame);
        for (int i = 47; i >= 0; i--) begin
            wait_pulse();
            sd_cmd_in = frame[i];
            @(posedge clk);
        end
        #1 sd_cmd_in = 1'b1;
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [31:0] status, input int flip, input logic inj,
                          input int quiet);
        logic [39:0] c40, r40;
        logic [47:0] frame, rsp_exp;
        logic        pass, want_rsp, en_ok;
        int          v0, e0, got_k;
        c40 = {2'b01, idx, arg};
        frame = {c40, ref_crc7(c40), 1'b1};
        if (flip >= 0) frame[flip] = ~frame[flip];
        pass = frame[46] && frame[0] && (ref_crc7(frame[47:8]) == frame[7:1]);
        want_rsp = pass && !NO_RSP[idx];
        r40 = {2'b00, idx, status};
        rsp_exp = {r40, ref_crc7(r40) ^ {7{inj}}, 1'b1};
        if (pass) begin
            last_idx = idx;
            last_arg = arg;
        end
        card_status = status;
`ifdef SD_CARD_RSP_CRC_INJECT_EN
        rsp_crc_inject = inj;
`endif
        v0 = valid_pulses;
        e0 = err_pulses;
        rsp_got = 'x;
        send_frame(frame);
        if (want_rsp) begin
            got_k = 0;
            for (int k = 1; k <= 200 && got_k == 0; k++) begin
                sample_pulse();
                if (sd_cmd_en === 1'b1) got_k = k;
            end
            checks++;
            if (got_k != NCR) begin
                errors++;
                $display("FAIL ncr_delay cmd%0d: got %0d pulses, want %0d", idx, got_k, NCR);
            end
            if (got_k != 0) begin
                en_ok = 1'b1;
                rsp_got[47] = sd_cmd_out;
                for (int b = 46; b >= 0; b--) begin
                    sample_pulse();
                    rsp_got[b] = sd_cmd_out;
                    if (sd_cmd_en !== 1'b1) en_ok = 1'b0;
                end
                checks++;
                if (!en_ok) begin
                    errors++;
                    $display("FAIL rsp_drive_en cmd%0d: enable dropped during response", idx);
                end
                checks++;
                if (rsp_got !== rsp_exp) begin
                    errors++;
                    $display("FAIL rsp_bits cmd%0d: got %h want %h", idx, rsp_got, rsp_exp);
                end
                sample_pulse();
                checks++;
                if (sd_cmd_en !== 1'b0 || sd_cmd_out !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp_release cmd%0d: en=%b cmd=%b busy=%b want 0 1 0",
                             idx, sd_cmd_en, sd_cmd_out, busy);
                end
            end
        end else begin
            en_ok = 1'b1;
            for (int k = 0; k < quiet; k++) begin
                sample_pulse();
                if (sd_cmd_en !== 1'b0) en_ok = 1'b0;
            end
            checks++;
            if (!en_ok || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_rsp cmd%0d: line_quiet=%b busy=%b want 1 0", idx, en_ok, busy);
            end
        end
        checks++;
        if (valid_pulses - v0 != int'(pass) || err_pulses - e0 != int'(!pass)) begin
            errors++;
            $display("FAIL pulses cmd%0d: valid=%0d err=%0d want %0d %0d", idx,
                     valid_pulses - v0, err_pulses - e0, int'(pass), int'(!pass));
        end
        checks++;
        if (cmd_index !== last_idx || cmd_arg !== last_arg) begin
            errors++;
            $display("FAIL latched cmd%0d: idx=%0d arg=%h want %0d %h", idx, cmd_index,
                     cmd_arg, last_idx, last_arg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sd_cmd_out, sd_cmd_en, cmd_valid, cmd_err, busy} !== 5'b10000 ||
            cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: cmd=%b en=%b v=%b e=%b busy=%b idx=%0d arg=%h",
                     sd_cmd_out, sd_cmd_en, cmd_valid, cmd_err, busy, cmd_index, cmd_arg);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cmd0();
        do_cmd(6'd0, 32'd0, 32'hFFFF_FFFF, -1, 1'b0, 100);
    endtask

    task automatic test_cmd12();
        do_cmd(6'd12, 32'd0, 32'd0, -1, 1'b0, 10);
        checks++;
        if (rsp_got !== 48'h0C_0000_0000_F5) begin
            errors++;
            $display("FAIL cmd12_rsp: got %h want 0c00000000f5", rsp_got);
        end
    endtask

    task automatic test_cmd8();
        do_cmd(6'd8, 32'h0000_01AA, 32'h0000_0900, -1, 1'b0, 10);
        checks++;
        if (cmd_arg !== 32'h1AA) begin
            errors++;
            $display("FAIL cmd8_arg: got %h want 000001aa", cmd_arg);
        end
    endtask

    task automatic test_crc_error();
        // CMD17 arg 0 ends in 0x55; flipping bit 1 turns it into 0x57.
        do_cmd(6'd17, 32'd0, 32'h0, 1, 1'b0, 20);
    endtask

    task automatic test_reset_mid_send();
        logic [39:0] c40;
        int          got_k;
        c40 = {2'b01, 6'd12, 32'd0};
        card_status = 32'h1234_5678;
        send_frame({c40, ref_crc7(c40), 1'b1});
        got_k = 0;
        for (int k = 1; k <= 200 && got_k == 0; k++) begin
            sample_pulse();
            if (sd_cmd_en === 1'b1) got_k = k;
        end
        for (int b = 0; b < 20; b++) sample_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (got_k == 0 || sd_cmd_en !== 1'b0 || sd_cmd_out !== 1'b1 || busy !== 1'b0 ||
            cmd_index !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid_send: started=%0d en=%b cmd=%b busy=%b idx=%0d",
                     got_k, sd_cmd_en, sd_cmd_out, busy, cmd_index);
        end
        last_idx = '0;
        last_arg = '0;
        @(negedge clk);
        rst = 1'b0;
        do_cmd(6'd12, 32'd0, 32'd0, -1, 1'b0, 10);
    endtask

    task automatic test_random();
        int flip;
        for (int n = 0; n < 14; n++) begin
            flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 46)) : -1;
            do_cmd(6'($urandom_range(0, 63)), $urandom, $urandom, flip, 1'b0, 10);
        end
    endtask

`ifdef SD_CARD_RSP_CRC_INJECT_EN
    task automatic test_inject();
        do_cmd(6'd12, 32'd0, 32'd0, -1, 1'b1, 10);
        checks++;
        if (rsp_got !== 48'h0C_0000_0000_0B) begin
            errors++;
            $display("FAIL inject_rsp: got %h want 0c000000000b", rsp_got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cmd0();
        test_cmd12();
        test_cmd8();
        test_crc_error();
        test_reset_mid_send();
        test_random();
`ifdef SD_CARD_RSP_CRC_INJECT_EN
        test_inject();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
Synthesizable SD-card-side CMD-line endpoint: the counterpart of the host command path in sdhci_top.
- Receives 48-bit host commands on the CMD line and checks framing and CRC7.
- Returns R1-style 48-bit responses built from a card status input.
- Used as an in-tree card model for host testbenches such as the auto-CMD12, timeout and CRC-error benches; FPGA loopback use is also intended.
- Runs in the host/system clock domain; a one-cycle enable pulse marks each SD clock rising edge.

Parameters:
- NcrCycles, 2: SD clock periods between the command end bit and the response start bit; legal range 2..64.
- NoRspMask, 64'h1: bit i set means command index i gets no response (CMD0 by default).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- sd_clk_en_i  in  1  one-cycle pulse per SD clock rising edge; all sampling and driving is gated by it.
- sd_cmd_i  in  1  CMD line from the host; idle level 1.
- sd_cmd_o  out  1  CMD line value driven by the card.
- sd_cmd_en_o  out  1  card drives the CMD line.
- card_status_i  in  32  R1 card status; captured when the response starts.
- cmd_valid_o  out  1  one-cycle pulse when a received command passes all checks.
- cmd_index_o  out  6  index of the last valid command.
- cmd_arg_o  out  32  argument of the last valid command.
- cmd_err_o  out  1  one-cycle pulse on CRC, transmission-bit or end-bit error.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset is synchronous and active-high; one clock clk_i, reset rst_i.
- Reset values: sd_cmd_o=1, sd_cmd_en_o=0, cmd_valid_o=0, cmd_err_o=0, busy_o=0, cmd_index_o=0, cmd_arg_o=0; FSM enters IDLE.
- Sampling: all CMD line sampling and all output-bit changes occur only in cycles with sd_clk_en_i=1.
- IDLE: on sd_cmd_i==0 at an enable pulse, that start bit counts as bit 47 and the FSM moves to RECV.
- RECV:
  - Shift-in is MSB first; 47 more bits are shifted at enable pulses.
  - CRC7 (polynomial x^7+x^3+1, register init 0) runs over bits 47..8.
  - After bit 0 the FSM moves to CHECK.
- CHECK (single clk_i cycle, no enable needed):
  - Pass conditions: bit46==1 (host direction), computed CRC == bits 7..1, bit0==1.
  - Pass: pulse cmd_valid_o, latch cmd_index_o and cmd_arg_o. If NoRspMask[index] is set, go to IDLE; otherwise go to WAIT_NCR.
  - Fail: pulse cmd_err_o, go to IDLE with no response.
- WAIT_NCR:
  - Count NcrCycles enable pulses with sd_cmd_en_o=0.
  - On the final pulse, capture card_status_i and assert sd_cmd_en_o with sd_cmd_o=0 (start bit); move to SEND.
- SEND: drive one bit per enable pulse in this order:
  - direction bit 0;
  - index, 6 bits, MSB first;
  - status, 32 bits, MSB first;
  - CRC7 over the first 40 bits, 7 bits;
  - end bit 1.
  - At the enable pulse after the end bit: sd_cmd_en_o=0, sd_cmd_o=1, go to IDLE.
- sd_cmd_i is ignored in WAIT_NCR and SEND (no collision detection).
- A new command may start on the first enable pulse after return to IDLE.
- sd_clk_en_i stuck at 0 freezes the FSM indefinitely; there is no timeout.
- Reset mid-operation: outputs take their reset values in the next clk_i cycle and any partial command is discarded.

Optional Feature:
- Macro: SD_CARD_RSP_CRC_INJECT_EN.
- Defined: adds input port rsp_crc_inject_i (1 bit), sampled together with card_status_i. When it is 1, the transmitted response CRC is bitwise inverted, exercising host CRC-error paths (e.g. 0x7A is sent as 0x05).
- Undefined: the port is absent and the CRC is always correct.

Decomposition:
- Package sd_card_pkg holds:
  - state enum: IDLE, RECV, CHECK, WAIT_NCR, SEND;
  - constants CmdLen=48, CrcPoly=7'h09, CrcWidth=7;
  - function crc7_next(crc, bit).
- Sub-module sd_crc7: serial CRC7 with clear and enable inputs. Two instances are used, one for receive and one for transmit.

Test Plan:
- CMD0, bytes 40 00 00 00 00 95 -> cmd_valid_o pulse, cmd_index_o=0, no response; sd_cmd_en_o stays 0 for 100 SD periods.
- CMD12 with arg 0 (4C 00 00 00 00 61), card_status_i=0, NcrCycles=2 -> start bit 2 periods after the end bit; response bits 0,0,001100, 32 zeros, CRC 0x7A, then 1.
- CMD8 with arg 0x000001AA (48 00 00 01 AA 87), card_status_i=32'h00000900 -> cmd_arg_o=0x1AA; response index 8, status 0x900, CRC matches the reference model.
- CMD17 with last byte 0x55 corrupted to 0x57 -> cmd_err_o pulse, cmd_valid_o stays 0, no response, busy_o returns to 0.
- Reset asserted during SEND bit 20 -> next cycle sd_cmd_en_o=0 and sd_cmd_o=1; a following valid CMD12 is answered normally.
- With SD_CARD_RSP_CRC_INJECT_EN defined and rsp_crc_inject_i=1 on CMD12 -> response CRC field = 0x05; all other bits unchanged.
